// File: rtl/calc_pkg.sv
// calc_pkg: shared constants for the calculator request sequencer.
//   Command codes (NOP/ADD/SUB/LSH/RSH), response codes and the sequencer
//   FSM state type, plus a helper that says which commands are dispatched.
package calc_pkg;

   localparam logic [3:0] CMD_NOP = 4'd0;
   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_LSH = 4'd5;
   localparam logic [3:0] CMD_RSH = 4'd6;

   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_OK   = 2'd1;
   localparam logic [1:0] RESP_ERR  = 2'd2;
   localparam logic [1:0] RESP_REJ  = 2'd3;  // local reject or timeout

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_OPND,
      S_WAIT,
      S_DONE
   } seq_state_t;

   // Only these commands are sent to a calculator port; anything else is
   // rejected locally without touching the port.
   function automatic logic is_dispatch_cmd(input logic [3:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
             (cmd == CMD_LSH) || (cmd == CMD_RSH);
   endfunction

endpackage

// File: rtl/calc_seq_fifo.sv
// calc_seq_fifo: transaction queue for the request sequencer.
//   c_clk/reset : clock, async active-low reset (queue empties on reset)
//   push/wr_data: write an entry; ignored while full
//   pop/rd_data : show-ahead head entry; pop ignored while empty
//   full/empty  : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module calc_seq_fifo
   import calc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             c_clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge c_clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/calc_req_sequencer.sv
// calc_req_sequencer: queues calculator transactions and drives them, one
// at a time, onto NUM_PORTS calculator request ports.
//   c_clk, reset         : clock, async active-low reset
//   tx_*                 : transaction input (valid/ready, cmd, port, op1, op2)
//   req_cmd_out/data_out : flattened per-port request (4 / DATA_W bits each)
//   out_resp/out_data    : flattened per-port calculator response and result
//   rsp_*                : one-cycle completion report (port, code, data)
// Sequence per transaction: IDLE(pop) -> CMD(cmd/op1) -> OPND(0/op2) ->
// WAIT(until response or TIMEOUT) -> DONE(rsp_valid) -> IDLE.
module calc_req_sequencer
   import calc_pkg::*;
#(
   parameter int  NUM_PORTS = 4,
   parameter int  DATA_W    = 32,
   parameter int  DEPTH     = 8,
   parameter int  TIMEOUT   = 64,
   localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                          c_clk,
   input  logic                          reset,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   input  logic [3:0]                    tx_cmd,
   input  logic [PORT_W-1:0]             tx_port,
   input  logic [DATA_W-1:0]             tx_op1,
   input  logic [DATA_W-1:0]             tx_op2,
   output logic [NUM_PORTS*4-1:0]        req_cmd_out,
   output logic [NUM_PORTS*DATA_W-1:0]   req_data_out,
   input  logic [NUM_PORTS*2-1:0]        out_resp,
   input  logic [NUM_PORTS*DATA_W-1:0]   out_data,
   output logic                          rsp_valid,
   output logic [PORT_W-1:0]             rsp_port,
   output logic [1:0]                    rsp_code,
   output logic [DATA_W-1:0]             rsp_data
);

   localparam int ENT_W  = 4 + PORT_W + 2*DATA_W;
   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   seq_state_t                        state;
   logic                              fifo_full;
   logic                              fifo_empty;
   logic                              fifo_pop;
   logic [ENT_W-1:0]                  head;
   logic [3:0]                        head_cmd;
   logic [PORT_W-1:0]                 head_port;
   logic [DATA_W-1:0]                 head_op1;
   logic [DATA_W-1:0]                 head_op2;
   logic [PORT_W-1:0]                 cur_port;
   logic [DATA_W-1:0]                 cur_op2;
   logic [3:0]                        drv_cmd;
   logic [DATA_W-1:0]                 drv_data;
   logic [WAIT_W-1:0]                 wait_cnt;
   logic [NUM_PORTS-1:0][1:0]         resp_v;
   logic [NUM_PORTS-1:0][DATA_W-1:0]  data_v;
   logic [1:0]                        tgt_resp;
   logic [DATA_W-1:0]                 tgt_data;

   assign tx_ready = !fifo_full;
   assign fifo_pop = (state == S_IDLE) && !fifo_empty;
   assign {head_cmd, head_port, head_op1, head_op2} = head;

   calc_seq_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .c_clk   (c_clk),
      .reset   (reset),
      .push    (tx_valid),
      .wr_data ({tx_cmd, tx_port, tx_op1, tx_op2}),
      .pop     (fifo_pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Only the target port ever sees the drive registers; they hold zero
   // outside CMD/OPND, so every port idles at 0/0.
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign req_cmd_out[4*p +: 4]       = (cur_port == PORT_W'(p)) ? drv_cmd  : 4'd0;
      assign req_data_out[DATA_W*p +: DATA_W] = (cur_port == PORT_W'(p)) ? drv_data : '0;
   end

   assign resp_v   = out_resp;
   assign data_v   = out_data;
   assign tgt_resp = resp_v[cur_port];
   assign tgt_data = data_v[cur_port];

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         cur_port  <= '0;
         cur_op2   <= '0;
         drv_cmd   <= CMD_NOP;
         drv_data  <= '0;
         wait_cnt  <= '0;
         rsp_valid <= 1'b0;
         rsp_port  <= '0;
         rsp_code  <= RESP_NONE;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!fifo_empty) begin
                  cur_port <= head_port;
                  cur_op2  <= head_op2;
                  if (is_dispatch_cmd(head_cmd)) begin
                     drv_cmd  <= head_cmd;
                     drv_data <= head_op1;
                     state    <= S_CMD;
                  end else begin
                     rsp_valid <= 1'b1;
                     rsp_port  <= head_port;
                     rsp_code  <= RESP_REJ;
                     rsp_data  <= '0;
                     state     <= S_DONE;
                  end
               end
            end
            S_CMD: begin
               drv_cmd  <= CMD_NOP;
               drv_data <= cur_op2;
               state    <= S_OPND;
            end
            S_OPND: begin
               drv_data <= '0;
               wait_cnt <= '0;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               // A response on the final WAIT cycle still wins over timeout.
               if (tgt_resp != RESP_NONE) begin
                  rsp_valid <= 1'b1;
                  rsp_port  <= cur_port;
                  rsp_code  <= tgt_resp;
                  rsp_data  <= tgt_data;
                  state     <= S_DONE;
               end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                  rsp_valid <= 1'b1;
                  rsp_port  <= cur_port;
                  rsp_code  <= RESP_REJ;
                  rsp_data  <= '0;
                  state     <= S_DONE;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calc_req_sequencer.sv
// Bench for calc_req_sequencer: table of directed transactions, hand-written
// fill/reset sequences and a randomized run, all scored against a
// transaction-level model (expected completions queued in push order).
module tb_calc_req_sequencer;

   localparam int NP = 4;
   localparam int DW = 32;
   localparam int DEP = 8;
   localparam int TO = 64;

   typedef struct {
      logic [3:0]  cmd;
      logic [1:0]  port;
      logic [31:0] op1;
      logic [31:0] op2;
      int          delay;   // WAIT cycle index at which the calculator answers
      logic [1:0]  code;
      logic [31:0] data;
   } plan_t;

   typedef struct {
      logic [1:0]  port;
      logic [1:0]  code;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      string       name;
      logic [3:0]  cmd;
      logic [1:0]  port;
      logic [31:0] op1;
      logic [31:0] op2;
      int          delay;
      logic [1:0]  code;
      logic [31:0] data;
      logic [1:0]  exp_code;
      logic [31:0] exp_data;
      int          exp_lat;  // accept edge -> rsp_valid cycle
   } vec_t;

   logic              c_clk;
   logic              reset;
   logic              tx_valid;
   logic              tx_ready;
   logic [3:0]        tx_cmd;
   logic [1:0]        tx_port;
   logic [DW-1:0]     tx_op1;
   logic [DW-1:0]     tx_op2;
   logic [NP*4-1:0]   req_cmd_out;
   logic [NP*DW-1:0]  req_data_out;
   logic [NP*2-1:0]   out_resp;
   logic [NP*DW-1:0]  out_data;
   logic              rsp_valid;
   logic [1:0]        rsp_port;
   logic [1:0]        rsp_code;
   logic [DW-1:0]     rsp_data;

   calc_req_sequencer #(
      .NUM_PORTS (NP),
      .DATA_W    (DW),
      .DEPTH     (DEP),
      .TIMEOUT   (TO)
   ) dut (
      .c_clk        (c_clk),
      .reset        (reset),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .tx_cmd       (tx_cmd),
      .tx_port      (tx_port),
      .tx_op1       (tx_op1),
      .tx_op2       (tx_op2),
      .req_cmd_out  (req_cmd_out),
      .req_data_out (req_data_out),
      .out_resp     (out_resp),
      .out_data     (out_data),
      .rsp_valid    (rsp_valid),
      .rsp_port     (rsp_port),
      .rsp_code     (rsp_code),
      .rsp_data     (rsp_data)
   );

   int    checks = 0;
   int    failures = 0;
   int    cyc = 0;
   int    rsp_cnt = 0;
   int    rsp_cyc = 0;
   plan_t plan_q[$];
   exp_t  exp_q[$];

   initial begin
      c_clk = 1'b0;
      forever #5 c_clk = ~c_clk;
   end

   always @(posedge c_clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 30) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic bit is_disp(input logic [3:0] cmd);
      return cmd inside {4'd1, 4'd2, 4'd5, 4'd6};
   endfunction

   // Transaction-level outcome: rejected commands and silent calculators
   // both report code 3 with zero data.
   function automatic exp_t model(input plan_t pl);
      exp_t e;
      e.port = pl.port;
      if (!is_disp(pl.cmd) || pl.delay >= TO) begin
         e.code = 2'd3;
         e.data = '0;
      end else begin
         e.code = pl.code;
         e.data = pl.data;
      end
      return e;
   endfunction

   // Calculator stand-in: checks the request phases on the ports and answers
   // the target port on the planned WAIT cycle; every other port is noisy.
   initial begin
      int          phase;
      int          wcnt;
      bit          quiet;
      bit          fire;
      plan_t       cur;
      logic [NP*4-1:0]  ec;
      logic [NP*DW-1:0] ed;
      phase = 0;
      wcnt = 0;
      cur = '{4'd0, 2'd0, 32'd0, 32'd0, 0, 2'd0, 32'd0};
      out_resp = '0;
      out_data = '0;
      forever begin
         @(posedge c_clk);
         #1;
         quiet = 1'b0;
         fire = 1'b0;
         if (!reset) begin
            phase = 0;
         end else begin
            case (phase)
               0: begin
                  if (req_cmd_out != '0) begin
                     if (plan_q.size() == 0) begin
                        chk("unexpected_dispatch", req_cmd_out, 0);
                     end else begin
                        cur = plan_q.pop_front();
                        ec = '0; ec[4*cur.port +: 4] = cur.cmd;
                        ed = '0; ed[DW*cur.port +: DW] = cur.op1;
                        chk("cmd_phase", {req_cmd_out, req_data_out}, {ec, ed});
                        quiet = 1'b1;
                        phase = 1;
                     end
                  end else begin
                     chk("idle_ports_zero", req_data_out, 0);
                  end
               end
               1: begin
                  ed = '0; ed[DW*cur.port +: DW] = cur.op2;
                  chk("opnd_phase", {req_cmd_out, req_data_out}, {16'h0, ed});
                  quiet = 1'b1;
                  wcnt = 0;
                  phase = 2;
               end
               default: begin
                  chk("wait_ports_zero", {req_cmd_out, req_data_out}, 0);
                  quiet = 1'b1;
                  fire = (wcnt == cur.delay);
                  wcnt++;
                  if (fire || wcnt == TO) phase = 0;
               end
            endcase
         end
         for (int p = 0; p < NP; p++) begin
            if (quiet && p == int'(cur.port)) begin
               out_resp[2*p +: 2]   = fire ? cur.code : 2'd0;
               out_data[DW*p +: DW] = fire ? cur.data : $urandom;
            end else begin
               out_resp[2*p +: 2]   = 2'($urandom_range(1, 3));
               out_data[DW*p +: DW] = $urandom;
            end
         end
      end
   end

   // Completion scoreboard.
   initial begin
      bit   prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(posedge c_clk);
         #1;
         if (!reset) begin
            prev = 1'b0;
         end else begin
            if (rsp_valid) begin
               chk("rsp_single_cycle", prev, 0);
               if (exp_q.size() == 0) begin
                  chk("rsp_unexpected", rsp_valid, 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("rsp_port_code_data", {rsp_port, rsp_code, rsp_data}, {e.port, e.code, e.data});
               end
               rsp_cnt++;
               rsp_cyc = cyc;
            end
            prev = rsp_valid;
         end
      end
   end

   task automatic push(input plan_t pl, output int acc);
      int guard;
      guard = 0;
      tx_valid = 1'b1;
      tx_cmd = pl.cmd;
      tx_port = pl.port;
      tx_op1 = pl.op1;
      tx_op2 = pl.op2;
      while (!tx_ready && guard < 2000) begin
         @(posedge c_clk);
         #1;
         guard++;
      end
      if (!tx_ready) begin
         chk("push_timeout", tx_ready, 1);
         tx_valid = 1'b0;
         acc = cyc;
         return;
      end
      @(posedge c_clk);
      #1;
      acc = cyc;
      tx_valid = 1'b0;
      exp_q.push_back(model(pl));
      if (is_disp(pl.cmd)) plan_q.push_back(pl);
   endtask

   task automatic push_exp(input plan_t pl, input exp_t ex, output int acc);
      int guard;
      guard = 0;
      tx_valid = 1'b1;
      tx_cmd = pl.cmd;
      tx_port = pl.port;
      tx_op1 = pl.op1;
      tx_op2 = pl.op2;
      while (!tx_ready && guard < 2000) begin
         @(posedge c_clk);
         #1;
         guard++;
      end
      if (!tx_ready) begin
         chk("push_timeout", tx_ready, 1);
         tx_valid = 1'b0;
         acc = cyc;
         return;
      end
      @(posedge c_clk);
      #1;
      acc = cyc;
      tx_valid = 1'b0;
      exp_q.push_back(ex);
      if (is_disp(pl.cmd)) plan_q.push_back(pl);
   endtask

   task automatic run_vec(input vec_t v);
      plan_t pl;
      exp_t  ex;
      int    acc;
      int    base;
      int    guard;
      pl = '{v.cmd, v.port, v.op1, v.op2, v.delay, v.code, v.data};
      ex = '{v.port, v.exp_code, v.exp_data};
      base = rsp_cnt;
      push_exp(pl, ex, acc);
      guard = 0;
      while (rsp_cnt == base && guard < 300) begin
         @(posedge c_clk);
         #2;
         guard++;
      end
      chk({v.name, "_done"}, rsp_cnt - base, 1);
      chk({v.name, "_latency"}, rsp_cyc - acc, v.exp_lat);
      @(posedge c_clk);
      #1;
   endtask

   task automatic drain(input string nm, input int budget);
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < budget) begin
         @(posedge c_clk);
         #2;
         guard++;
      end
      chk({nm, "_drained"}, exp_q.size(), 0);
      repeat (2) @(posedge c_clk);
      #1;
   endtask

   function automatic plan_t gen(input bit short_delay);
      plan_t pl;
      if ($urandom_range(0, 9) < 7) begin
         case ($urandom_range(0, 3))
            0:       pl.cmd = 4'd1;
            1:       pl.cmd = 4'd2;
            2:       pl.cmd = 4'd5;
            default: pl.cmd = 4'd6;
         endcase
      end else begin
         pl.cmd = 4'($urandom_range(0, 15));
      end
      pl.port = 2'($urandom_range(0, NP - 1));
      pl.op1 = $urandom;
      pl.op2 = $urandom;
      if (short_delay) pl.delay = $urandom_range(0, 2);
      else if ($urandom_range(0, 9) == 0) pl.delay = $urandom_range(TO - 2, TO + 2);
      else pl.delay = $urandom_range(0, 6);
      pl.code = 2'($urandom_range(1, 2));
      pl.data = $urandom;
      return pl;
   endfunction

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: got time-limit expired expected run complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      vec_t  vecs[8];
      plan_t pl;
      int    acc;
      int    acc0;
      int    base;
      int    guard;

      vecs[0] = '{"add_p0",        4'h1, 2'd0, 32'hFFFF0000, 32'h0000FFFF, 0,      2'd1, 32'hFFFFFFFF, 2'd1, 32'hFFFFFFFF, 4};
      vecs[1] = '{"reject_cmd3_p2", 4'h3, 2'd2, 32'h11111111, 32'h22222222, 0,     2'd1, 32'h00000000, 2'd3, 32'h00000000, 1};
      vecs[2] = '{"sub_p3_err",    4'h2, 2'd3, 32'h00000010, 32'h00000020, 3,      2'd2, 32'h12345678, 2'd2, 32'h12345678, 7};
      vecs[3] = '{"nop_p1",        4'h0, 2'd1, 32'h00000001, 32'h00000002, 0,      2'd1, 32'h00000005, 2'd3, 32'h00000000, 1};
      vecs[4] = '{"lsh_last_wait", 4'h5, 2'd2, 32'h000000A5, 32'h00000004, TO - 1, 2'd1, 32'h000000A5, 2'd1, 32'h000000A5, 4 + TO - 1};
      vecs[5] = '{"rsh_timeout",   4'h6, 2'd1, 32'h80000000, 32'h00000001, TO,     2'd1, 32'hDEADBEEF, 2'd3, 32'h00000000, 3 + TO};
      vecs[6] = '{"reject_cmdF_p3", 4'hF, 2'd3, 32'h0000AAAA, 32'h0000BBBB, 0,     2'd1, 32'h00000007, 2'd3, 32'h00000000, 1};
      vecs[7] = '{"add_p1_post_rst", 4'h1, 2'd1, 32'h00000003, 32'h00000004, 1,    2'd1, 32'h0000CAFE, 2'd1, 32'h0000CAFE, 5};

      reset = 1'b0;
      tx_valid = 1'b0;
      tx_cmd = '0;
      tx_port = '0;
      tx_op1 = '0;
      tx_op2 = '0;
      repeat (3) @(posedge c_clk);
      #1;
      chk("reset_outputs", {req_cmd_out, req_data_out, rsp_valid, rsp_port, rsp_code, rsp_data}, 0);
      reset = 1'b1;
      @(posedge c_clk);
      #1;
      chk("ready_after_reset", tx_ready, 1);

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Nine silent transactions: one goes in flight, eight fill the queue.
      base = rsp_cnt;
      acc0 = 0;
      for (int i = 0; i < 9; i++) begin
         pl = '{4'd1, 2'(i % NP), 32'(i), 32'(i * 3), TO + 5, 2'd1, 32'd0};
         push(pl, acc);
         if (i == 0) acc0 = acc;
         chk("fill_ready", tx_ready, (i < 8) ? 1 : 0);
      end
      guard = 0;
      while (rsp_cnt == base && guard < 200) begin
         @(posedge c_clk);
         #2;
         guard++;
      end
      chk("timeout_latency", rsp_cyc - acc0, 3 + TO);
      drain("silent_fill", 1500);
      chk("silent_fill_count", rsp_cnt - base, 9);

      // Reset while the first transaction sits in WAIT and a second is queued.
      pl = '{4'd1, 2'd2, 32'h1, 32'h2, TO + 5, 2'd1, 32'd0};
      push(pl, acc);
      pl = '{4'd2, 2'd1, 32'h5, 32'h6, 0, 2'd1, 32'h77};
      push(pl, acc);
      repeat (5) @(posedge c_clk);
      #3;
      reset = 1'b0;
      plan_q.delete();
      exp_q.delete();
      #1;
      chk("mid_reset_outputs", {req_cmd_out, req_data_out, rsp_valid, rsp_port, rsp_code, rsp_data}, 0);
      repeat (2) @(posedge c_clk);
      #1;
      chk("mid_reset_hold", {req_cmd_out, req_data_out, rsp_valid, rsp_port, rsp_code, rsp_data}, 0);
      reset = 1'b1;
      base = rsp_cnt;
      @(posedge c_clk);
      #1;
      chk("ready_after_mid_reset", tx_ready, 1);
      repeat (TO + 10) @(posedge c_clk);
      #2;
      chk("no_rsp_after_reset", rsp_cnt - base, 0);
      run_vec(vecs[7]);

      // Back-to-back burst keeps the queue at or near full; pointers wrap.
      base = rsp_cnt;
      for (int i = 0; i < 24; i++) begin
         pl = gen(1'b1);
         push(pl, acc);
      end
      drain("burst", 2000);
      chk("burst_count", rsp_cnt - base, 24);

      // Randomized traffic with idle gaps.
      base = rsp_cnt;
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge c_clk);
         #1;
         pl = gen(1'b0);
         push(pl, acc);
      end
      drain("random", 10000);
      chk("random_count", rsp_cnt - base, 60);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
